// File: rtl/alu_pkg.sv
// Shared ALU operand types used by the issue block and the ALU itself.
package alu_pkg;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] in0;
        logic [DATA_W-1:0] in1;
        logic              opsel;
    } alu_req_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; the owner guarantees no push when full and no pop when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
endmodule

// File: rtl/alu_issue.sv
// Issues queued operations to a fixed-latency ALU and returns results in order,
// using response-FIFO credits so a returning result always has a slot.
module alu_issue
    import alu_pkg::*;
#(
    parameter int LATENCY   = 1,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_in0,
    input  logic [DATA_W-1:0] req_in1,
    input  logic              req_opsel,
    output logic [DATA_W-1:0] in0,
    output logic [DATA_W-1:0] in1,
    output logic              opsel,
    output logic              issue_valid,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    alu_req_t          req_wdata;
    alu_req_t          req_head;
    logic              req_push;
    logic              req_empty;
    logic              req_full;
    logic              issue;
    logic              rsp_push;
    logic              rsp_pop;
    logic              rsp_empty;
    logic              rsp_full;
    logic [DATA_W-1:0] rsp_head;
    logic [CW-1:0]     credit;
    logic [LATENCY-1:0] vld_sr;

    assign req_wdata.in0   = req_in0;
    assign req_wdata.in1   = req_in1;
    assign req_wdata.opsel = req_opsel;

    assign req_ready = ~reset & ~req_full;
    assign req_push  = req_valid & req_ready;

    // Credits count in-flight results plus queued responses.
    assign issue = ~reset & ~req_empty & (credit < CW'(RSP_DEPTH));

    always_comb begin
        issue_valid = issue;
        in0         = '0;
        in1         = '0;
        opsel       = 1'b0;
        if (issue) begin
            in0   = req_head.in0;
            in1   = req_head.in1;
            opsel = req_head.opsel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    assign rsp_push  = ~reset & vld_sr[LATENCY-1] & ~rsp_full;
    assign rsp_valid = ~reset & ~rsp_empty;
    assign rsp_data  = rsp_valid ? rsp_head : '0;
    assign rsp_pop   = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            credit <= '0;
        end else begin
            case ({issue, rsp_pop})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    sync_fifo #(.WIDTH($bits(alu_req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_push),
        .push_data (req_wdata),
        .pop       (issue),
        .pop_data  (req_head),
        .empty     (req_empty),
        .full      (req_full)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_push),
        .push_data (alu_out),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .empty     (rsp_empty),
        .full      (rsp_full)
    );
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter LATENCY, default 1: ALU cycles from an issue cycle to the matching alu_out cycle, range 1..4.
REQ-002 Parameter REQ_DEPTH, default 4: request FIFO entries, a power of 2.
REQ-003 Parameter RSP_DEPTH, default 4: response FIFO entries and credit limit, a power of 2.
REQ-004 clk  input  1  single clock; every flop updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  an operation is offered.
REQ-007 req_ready  output  1  the block accepts the offered operation this cycle.
REQ-008 req_in0  input  32  first operand.
REQ-009 req_in1  input  32  second operand.
REQ-010 req_opsel  input  1  operation select, forwarded unchanged.
REQ-011 in0  output  32  operand to the ALU.
REQ-012 in1  output  32  operand to the ALU.
REQ-013 opsel  output  1  operation select to the ALU.
REQ-014 issue_valid  output  1  in0/in1/opsel carry a real operation this cycle.
REQ-015 alu_out  input  32  ALU result, meaningful LATENCY cycles after an issue.
REQ-016 rsp_valid  output  1  rsp_data holds a result.
REQ-017 rsp_ready  input  1  the consumer takes the result this cycle.
REQ-018 rsp_data  output  32  result, in request order.

Function
REQ-019 A request is accepted when req_valid and req_ready are both 1 on a rising edge.
REQ-020 Accepted requests are pushed into the request FIFO.
REQ-021 req_ready = request FIFO not full, registered; it does not depend on a same-cycle pop.
REQ-022 Credit count C = in-flight operations + response FIFO occupancy; C never exceeds RSP_DEPTH.
REQ-023 An issue occurs in any cycle where the request FIFO is non-empty and C < RSP_DEPTH.
REQ-024 On an issue, the head entry drives in0/in1/opsel, issue_valid=1, and the entry pops at the clock edge.
REQ-025 In non-issue cycles: issue_valid=0, in0=0, in1=0, opsel=0.
REQ-026 Latency: a request accepted at edge N issues in cycle N+1.
REQ-027 A LATENCY-deep valid shift register tracks issues.
REQ-028 When the tail bit of that shift register is 1, alu_out is pushed into the response FIFO.
REQ-029 rsp_valid is 1 in cycle N+2+LATENCY at the earliest.
REQ-030 Response FIFO: rsp_valid = not empty; rsp_data = head entry.
REQ-031 The response FIFO head pops on rsp_valid && rsp_ready.
REQ-032 rsp_data holds stable while rsp_valid=1 and rsp_ready=0.
REQ-033 Credit update:
- C increments on an issue.
- C decrements on a response pop.
- An issue and a pop in the same cycle leave C unchanged.
REQ-034 A response push never finds the response FIFO full; credits guarantee this.
REQ-035 Results leave in strict acceptance order.
REQ-036 Throughput: 1 operation per cycle sustained when rsp_ready is held at 1.
REQ-037 FIFO pointers wrap modulo depth.
REQ-038 A push and a pop on the same FIFO in one cycle keep the occupancy unchanged; this is legal when the FIFO is non-empty and not full.

Reset
REQ-039 While reset=1, both FIFOs, the valid shift register and C are cleared.
REQ-040 While reset=1: req_ready=0, issue_valid=0, rsp_valid=0, in0/in1/opsel/rsp_data=0.
REQ-041 Reset mid-operation discards all queued and in-flight operations.
REQ-042 An alu_out arriving after reset is not captured.
REQ-043 req_ready=1 in the first cycle after reset deasserts.

Structure
REQ-044 Package alu_pkg holds the DATA_W=32 constant and a packed struct alu_req_t {in0, in1, opsel}, shared with the alu block.
REQ-045 Sub-module sync_fifo is parameterised by width and depth.
REQ-046 sync_fifo is instantiated twice: requests use alu_req_t; responses use 32 bits.

Verification
REQ-047 Single operation, LATENCY=1: accept {2,4,opsel=1} at edge N -> issue_valid=1 with in0=2, in1=4 in cycle N+1 -> rsp_valid=1 with rsp_data equal to the model result in cycle N+3. The bench ALU model computes in0+in1 for opsel=1 and in0-in1 for opsel=0, delayed LATENCY cycles.
REQ-048 Stream, rsp_ready held at 1: 8 back-to-back requests with in0=i, in1=1 -> 8 results in order, with no bubble after the first.
REQ-049 Backpressure, rsp_ready held at 0: send 10 requests.
- Exactly RSP_DEPTH=4 issues occur.
- req_ready drops after 4 more requests fill the request FIFO.
- Raising rsp_ready drains all 10 results in order.
REQ-050 Simultaneous events, C at its limit: an issue and a pop in the same cycle keep C constant and lose no result.
REQ-051 Reset mid-stream: assert reset with 3 operations in flight -> rsp_valid=0 for good. Then {2,4,opsel=0} -> a single result 0xFFFFFFFE.
